// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit with sub-word read-modify-write.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    MERGE_WR = 2'b10,
    RESP     = 2'b11
  } state_t;

  // Reserved size counts as an alignment error so it takes the same error path.
  function automatic logic misaligned(input size_t size, input logic [1:0] off);
    case (size)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      SZ_RSV:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: extracts/extends load data and merges store data into a memory word.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  size_t            size,
  input  logic [1:0]       off,
  input  logic             sign,
  input  logic [XLEN-1:0]  rd,
  input  logic [XLEN-1:0]  wd,
  output logic [XLEN-1:0]  ld_word,
  output logic [XLEN-1:0]  st_word
);

  logic [1:0]  bsel;
  logic        hsel;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // Big-endian mirrors the lane index within the word.
    bsel    = BIG_ENDIAN ? (2'd3 - off) : off;
    hsel    = BIG_ENDIAN ? ~off[1] : off[1];
    byte_v  = rd[{bsel, 3'b000} +: 8];
    half_v  = rd[{hsel, 4'b0000} +: 16];
    ld_word = rd;
    st_word = wd;
    case (size)
      SZ_B: begin
        ld_word = {{24{sign & byte_v[7]}}, byte_v};
        st_word = rd;
        st_word[{bsel, 3'b000} +: 8] = wd[7:0];
      end
      SZ_H: begin
        ld_word = {{16{sign & half_v[15]}}, half_v};
        st_word = rd;
        st_word[{hsel, 4'b0000} +: 16] = wd[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: byte/halfword/word accesses to a word-indexed memory, sub-word stores by RMW.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             wr,
  input  logic [1:0]       size,
  input  logic             sign_ld,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [XLEN-1:0]  rdata,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_a,
  output logic [XLEN-1:0]  mem_wd,
  input  logic [XLEN-1:0]  mem_rd
);

  state_t          state;
  logic            wr_q;
  size_t           size_q;
  logic            sign_q;
  logic            err_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] merge_q;
  logic [XLEN-1:0] ld_word;
  logic [XLEN-1:0] st_word;
  logic            bad;

  lsu_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .size    (size_q),
    .off     (addr_q[1:0]),
    .sign    (sign_q),
    .rd      (mem_rd),
    .wd      (wdata_q),
    .ld_word (ld_word),
    .st_word (st_word)
  );

  assign bad = misaligned(size_t'(size), addr[1:0]);

  // Memory-side signals come only from latched state; reset masks any pending write.
  assign mem_a  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_we = we_q & ~reset;
  assign mem_wd = (state == MERGE_WR) ? merge_q : wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_B;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wr_q    <= wr;
            size_q  <= size_t'(size);
            sign_q  <= sign_ld;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= bad;
            busy    <= 1'b1;
            if (bad) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= ACCESS;
              we_q  <= wr & (size_t'(size) == SZ_W);
            end
          end
        end
        ACCESS: begin
          if (!wr_q) begin
            rdata <= ld_word;
            state <= RESP;
            done  <= 1'b1;
            err   <= err_q;
          end else if (size_q == SZ_W) begin
            we_q  <= 1'b0;
            state <= RESP;
            done  <= 1'b1;
            err   <= err_q;
          end else begin
            merge_q <= st_word;
            we_q    <= 1'b1;
            state   <= MERGE_WR;
          end
        end
        MERGE_WR: begin
          we_q  <= 1'b0;
          state <= RESP;
          done  <= 1'b1;
          err   <= err_q;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
